// File: rtl/fb_scanout.sv
// fb_scanout: 640x480@60 VGA scan-out of the 256x176 frame buffer, 2x2 scaled and centred.
module fb_scanout #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned X_OFFSET  = 64,
   parameter int unsigned Y_OFFSET  = 64,
   parameter int unsigned FB_WIDTH  = 256,
   parameter int unsigned FB_HEIGHT = 176
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [5:0]  fb_q,
   output logic [15:0] fb_rd_address,
   output logic        fb_rd_en,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N,
   output logic        VGA_CLK,
   output logic        vblank,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HW           = $clog2(H_TOTAL);
   localparam int unsigned VW           = $clog2(V_TOTAL);
   localparam int unsigned XW           = $clog2(FB_WIDTH);
   localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam int unsigned X_END        = X_OFFSET + 2 * FB_WIDTH;
   localparam int unsigned Y_END        = Y_OFFSET + 2 * FB_HEIGHT;

   logic          pix_en;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          s1_visible;
   logic          s1_hsync;
   logic          s1_vsync;

   logic          h_last_c;
   logic          v_last_c;
   logic          in_img_c;
   logic          visible_c;
   logic          hsync_c;
   logic          vsync_c;
   logic [HW-1:0] img_x_c;
   logic [VW-1:0] img_y_c;
   logic [15:0]   addr_c;

   // 2-bit channel to 8-bit by bit replication (01 -> 55, 10 -> AA, 11 -> FF)
   function automatic logic [7:0] expand(input logic [1:0] c);
      return {4{c}};
   endfunction

   assign VGA_SYNC_N = 1'b0;

   // Position decode for the pixel currently addressed by the counters
   always_comb begin
      h_last_c  = (h_cnt == HW'(H_TOTAL - 1));
      v_last_c  = (v_cnt == VW'(V_TOTAL - 1));
      in_img_c  = (h_cnt >= HW'(X_OFFSET)) && (h_cnt < HW'(X_END)) &&
                  (v_cnt >= VW'(Y_OFFSET)) && (v_cnt < VW'(Y_END));
      visible_c = (h_cnt < HW'(H_VISIBLE)) && (v_cnt < VW'(V_VISIBLE));
      hsync_c   = (h_cnt >= HW'(H_SYNC_START)) && (h_cnt < HW'(H_SYNC_END));
      vsync_c   = (v_cnt >= VW'(V_SYNC_START)) && (v_cnt < VW'(V_SYNC_END));
      img_x_c   = h_cnt - HW'(X_OFFSET);
      img_y_c   = v_cnt - VW'(Y_OFFSET);
      addr_c    = (16'(img_y_c >> 1) << XW) | 16'(img_x_c >> 1);
   end

   // Pixel enable at half the system clock; VGA_CLK is a flop copy of it
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pix_en  <= 1'b0;
         VGA_CLK <= 1'b0;
      end else begin
         pix_en  <= ~pix_en;
         VGA_CLK <= ~pix_en;
      end
   end

   // Horizontal and vertical scan counters
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_last_c) begin
            h_cnt <= '0;
            v_cnt <= v_last_c ? '0 : v_cnt + VW'(1);
         end else begin
            h_cnt <= h_cnt + HW'(1);
         end
      end
   end

   // Stage 1: issue the frame buffer read and capture timing flags
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         fb_rd_address <= '0;
         fb_rd_en      <= 1'b0;
         s1_visible    <= 1'b0;
         s1_hsync      <= 1'b0;
         s1_vsync      <= 1'b0;
      end else if (pix_en) begin
         fb_rd_en   <= in_img_c;
         s1_visible <= visible_c;
         s1_hsync   <= hsync_c;
         s1_vsync   <= vsync_c;
         if (in_img_c) begin
            fb_rd_address <= addr_c;
         end
      end
   end

   // Stage 2: drive colour and syncs one pixel period after the address
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
      end else if (pix_en) begin
         VGA_HS      <= ~s1_hsync;
         VGA_VS      <= ~s1_vsync;
         VGA_BLANK_N <= s1_visible;
         if (fb_rd_en && s1_visible) begin
            VGA_R <= expand(fb_q[5:4]);
            VGA_G <= expand(fb_q[3:2]);
            VGA_B <= expand(fb_q[1:0]);
         end else begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
         end
      end
   end

   // Frame status straight from the counters
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         vblank      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         vblank      <= (v_cnt >= VW'(V_VISIBLE));
         frame_start <= pix_en && h_last_c && v_last_c;
      end
   end

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: random frame buffer contents checked against a position-based scan model.
// Vertical timing is shortened so a whole frame fits in a short run; horizontal is full size.
module tb_fb_scanout;

   localparam int HV  = 640, HF = 16, HSY = 96, HB = 48;
   localparam int VV  = 20,  VF = 2,  VSY = 2,  VB = 3;
   localparam int XO  = 64,  YO = 4;
   localparam int FBW = 256, FBH = 6;
   localparam int HT  = HV + HF + HSY + HB;
   localparam int VT  = VV + VF + VSY + VB;
   localparam int FRAME = HT * VT;
   localparam int MEM_SIZE = FBW * FBH;

   logic        clock;
   logic        resetn;
   logic [5:0]  fb_q;
   logic [15:0] fb_rd_address;
   logic        fb_rd_en;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
   logic        vblank, frame_start;

   fb_scanout #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
      .X_OFFSET(XO), .Y_OFFSET(YO), .FB_WIDTH(FBW), .FB_HEIGHT(FBH)
   ) dut (
      .clock(clock), .resetn(resetn), .fb_q(fb_q),
      .fb_rd_address(fb_rd_address), .fb_rd_en(fb_rd_en),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
      .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK),
      .vblank(vblank), .frame_start(frame_start)
   );

   initial clock = 1'b0;
   always #10 clock = ~clock;

   logic [5:0] mem [MEM_SIZE];
   int checks   = 0;
   int failures = 0;
   int n        = 0;
   int last_addr = 0;
   int hs_run, blank_run, vs_run, vb_run, last_hs_fall, first_fs;

   task automatic finish_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   // Single comparison point: count it, report any mismatch
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
         if (failures >= 40) finish_run();
      end
   endtask

   function automatic int pos_h(int q); return q % HT; endfunction
   function automatic int pos_v(int q); return (q / HT) % VT; endfunction

   function automatic bit in_img(int q);
      int h = pos_h(q);
      int v = pos_v(q);
      return h >= XO && h < XO + 2 * FBW && v >= YO && v < YO + 2 * FBH;
   endfunction

   function automatic int img_addr(int q);
      return ((pos_v(q) - YO) / 2) * FBW + (pos_h(q) - XO) / 2;
   endfunction

   function automatic int chan(int c, int sh);
      return ((c >> sh) & 3) * 85;
   endfunction

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_addr"}, 32'(fb_rd_address), 0);
      check_eq({tag, "_en"}, 32'(fb_rd_en), 0);
      check_eq({tag, "_rgb"}, {8'h0, VGA_R, VGA_G, VGA_B}, 0);
      check_eq({tag, "_hs"}, 32'(VGA_HS), 1);
      check_eq({tag, "_vs"}, 32'(VGA_VS), 1);
      check_eq({tag, "_blank_n"}, 32'(VGA_BLANK_N), 0);
      check_eq({tag, "_vga_clk"}, 32'(VGA_CLK), 0);
      check_eq({tag, "_vblank"}, 32'(vblank), 0);
      check_eq({tag, "_frame_start"}, 32'(frame_start), 0);
      check_eq({tag, "_sync_n"}, 32'(VGA_SYNC_N), 0);
   endtask

   // Compare every output against the model for edge count n
   task automatic check_cycle();
      int q1, q2, h, v, c, er, eg, eb;
      bit hs, vs, bl;
      check_eq("vga_clk", 32'(VGA_CLK), 32'(n % 2));
      check_eq("sync_n", 32'(VGA_SYNC_N), 0);
      check_eq("vblank", 32'(vblank), 32'(n >= 1 && pos_v((n - 1) / 2) >= VV));
      check_eq("frame_start", 32'(frame_start),
               32'(n >= 2 && n % 2 == 0 && ((n / 2 - 1) % FRAME) == FRAME - 1));
      if (n >= 2) begin
         q1 = n / 2 - 1;
         if (in_img(q1)) last_addr = img_addr(q1);
         check_eq("rd_en", 32'(fb_rd_en), 32'(in_img(q1)));
         check_eq("rd_addr", 32'(fb_rd_address), 32'(last_addr));
         if (n % 2 == 0) begin
            h = pos_h(q1); v = pos_v(q1);
            if (h == 64 && v == YO) begin
               check_eq("addr_first", 32'(fb_rd_address), 0);
               check_eq("en_first", 32'(fb_rd_en), 1);
            end
            if (h == 65 && v == YO + 1) check_eq("addr_65_65", 32'(fb_rd_address), 0);
            if (h == 66 && v == YO) check_eq("addr_66", 32'(fb_rd_address), 1);
            if (h == 575 && v == YO + 2 * FBH - 1) check_eq("addr_last", 32'(fb_rd_address), 1535);
            if ((h == 63 || h == 576) && v == YO) check_eq("en_edge", 32'(fb_rd_en), 0);
         end
      end else begin
         check_eq("rd_en_early", 32'(fb_rd_en), 0);
         check_eq("rd_addr_early", 32'(fb_rd_address), 0);
      end
      if (n >= 4) begin
         q2 = n / 2 - 2;
         h = pos_h(q2); v = pos_v(q2);
         hs = !(h >= HV + HF && h < HV + HF + HSY);
         vs = !(v >= VV + VF && v < VV + VF + VSY);
         bl = (h < HV) && (v < VV);
         er = 0; eg = 0; eb = 0;
         if (in_img(q2)) begin
            c = int'(mem[img_addr(q2)]);
            er = chan(c, 4); eg = chan(c, 2); eb = chan(c, 0);
         end
         if (n % 2 == 0 && v == YO) begin
            if (h == 64) check_eq("rgb_first_pixel", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00FF55AA);
            if (h == 576) check_eq("rgb_after_img", {8'h0, VGA_R, VGA_G, VGA_B}, 0);
         end
      end else begin
         hs = 1; vs = 1; bl = 0; er = 0; eg = 0; eb = 0;
      end
      check_eq("hs", 32'(VGA_HS), 32'(hs));
      check_eq("vs", 32'(VGA_VS), 32'(vs));
      check_eq("blank_n", 32'(VGA_BLANK_N), 32'(bl));
      check_eq("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'((er << 16) | (eg << 8) | eb));
   endtask

   // Run lengths and spacing of sync/blank/frame events
   task automatic check_runs();
      if (VGA_HS == 1'b0) begin
         if (hs_run == 0 && last_hs_fall >= 0) check_eq("hs_period", 32'(n - last_hs_fall), 1600);
         if (hs_run == 0) last_hs_fall = n;
         hs_run++;
      end else if (hs_run > 0) begin
         check_eq("hs_low_len", 32'(hs_run), 192); hs_run = 0;
      end
      if (VGA_BLANK_N) blank_run++;
      else if (blank_run > 0) begin check_eq("blank_len", 32'(blank_run), 1280); blank_run = 0; end
      if (VGA_VS == 1'b0) vs_run++;
      else if (vs_run > 0) begin check_eq("vs_low_len", 32'(vs_run), 3200); vs_run = 0; end
      if (vblank) vb_run++;
      else if (vb_run > 0) begin check_eq("vblank_len", 32'(vb_run), (VT - VV) * 1600); vb_run = 0; end
      if (frame_start && first_fs < 0) begin
         first_fs = n;
         check_eq("frame_start_first", 32'(n), 2 * FRAME);
      end
   endtask

   task automatic clear_runs();
      hs_run = 0; blank_run = 0; vs_run = 0; vb_run = 0;
      last_hs_fall = -1; first_fs = -1;
   endtask

   // Advance cycles; RAM data appears one clock after the address, garbage otherwise
   task automatic run_cycles(input int count);
      for (int i = 0; i < count; i++) begin
         @(posedge clock);
         #1;
         n++;
         check_cycle();
         check_runs();
         if (n % 2 == 1) begin
            if (fb_rd_en && int'(fb_rd_address) < MEM_SIZE) fb_q = mem[fb_rd_address];
            else fb_q = 6'h3F;
         end else begin
            fb_q = 6'($urandom);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] = 6'($urandom);
      mem[0] = 6'b110110;
      fb_q   = 6'h3F;
      resetn = 1'b0;
      clear_runs();
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_reset_values("reset");
      resetn = 1'b1;
      n = 0;
      last_addr = 0;
      run_cycles(2 * FRAME + 2 * (6 * HT + 300));
      if (first_fs < 0) check_eq("frame_start_seen", 0, 1);

      // Mid-line reset inside the image: outputs drop immediately, scan restarts at (0,0)
      @(negedge clock);
      resetn = 1'b0;
      #1;
      check_reset_values("async_reset");
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1;
         check_reset_values("held_reset");
      end
      @(negedge clock);
      resetn = 1'b1;
      n = 0;
      last_addr = 0;
      clear_runs();
      check_reset_values("after_release");
      run_cycles(2 * (8 * HT));
      finish_run();
   end

endmodule
